// File: rtl/gpu_cell_framebuffer.sv
// Cell framebuffer (76x60 cells of 4x8 pixels) with a 16-entry 12-bit palette.
// Executes draw instructions one cell per cycle; returns pixel colour with 2-cycle latency.
module gpu_cell_framebuffer #(
  parameter int FB_W    = 76,
  parameter int FB_H    = 60,
  parameter int X_SHIFT = 2,
  parameter int Y_SHIFT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_pixel_x,
  input  logic [9:0]  i_pixel_y,
  output logic [11:0] o_color,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_ready,
  output logic        o_busy,
  output logic        o_error
);

  localparam int CELLS = FB_W * FB_H;
  localparam int AW    = $clog2(CELLS);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);
  localparam logic [6:0]    W_LIM    = 7'(FB_W);
  localparam logic [5:0]    H_LIM    = 6'(FB_H);
  localparam logic [9:0]    PX_LIM   = 10'(FB_W << X_SHIFT);
  localparam logic [9:0]    PY_LIM   = 10'(FB_H << Y_SHIFT);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic [6:0]      x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [5:0]      y_q, y_d, y1_q, y1_d;
  logic [AW-1:0]   base_q, base_d;
  logic [3:0]      idx_q, idx_d;
  logic            err_q, err_d;

  logic [11:0]     pal_q [16];
  logic [3:0]      fb_mem [CELLS];

  logic [1:0]      op;
  logic            accept;
  logic [6:0]      rx0, rx1;
  logic [5:0]      ry0, ry1;
  logic            rect_ok;
  logic            fb_we;
  logic [AW-1:0]   wr_addr;

  assign op      = i_instruction[31:30];
  assign accept  = i_instruction_ready && (state_q == IDLE);
  assign rx0     = i_instruction[25:19];
  assign ry0     = i_instruction[18:13];
  assign rx1     = i_instruction[12:6];
  assign ry1     = i_instruction[5:0];
  assign rect_ok = (rx0 <= rx1) && (ry0 <= ry1) && (rx1 < W_LIM) && (ry1 < H_LIM);
  assign fb_we   = (state_q == FILL);
  assign wr_addr = base_q + AW'(x_q);
  assign o_busy  = (state_q == FILL);
  assign o_error = err_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    base_d  = base_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept && op == 2'b01) begin
          x_d     = '0;
          y_d     = '0;
          x0_d    = '0;
          x1_d    = W_LIM - 7'd1;
          y1_d    = H_LIM - 6'd1;
          base_d  = '0;
          idx_d   = i_instruction[3:0];
          state_d = FILL;
        end else if (accept && op == 2'b10) begin
          if (rect_ok) begin
            x_d     = rx0;
            y_d     = ry0;
            x0_d    = rx0;
            x1_d    = rx1;
            y1_d    = ry1;
            base_d  = AW'(ry0) * ROW_STEP;
            idx_d   = i_instruction[29:26];
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        // Row base advances by one row stride so the write address never needs a multiply.
        if (x_q == x1_q) begin
          if (y_q == y1_q) begin
            state_d = IDLE;
          end else begin
            x_d    = x0_q;
            y_d    = y_q + 6'd1;
            base_d = base_q + ROW_STEP;
          end
        end else begin
          x_d = x_q + 7'd1;
        end
        if (i_instruction_ready) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= 12'h000;
    end else if (accept && op == 2'b00) begin
      pal_q[i_instruction[27:24]] <= i_instruction[11:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (fb_we) fb_mem[wr_addr] <= idx_q;
  end

  logic [9:0]    px_cell, py_cell;
  logic          in_range;
  logic [AW-1:0] rd_addr, rd_idx;
  logic [3:0]    rd_cell_q;
  logic          inr_q;
  logic [11:0]   color_q;

  assign px_cell  = i_pixel_x >> X_SHIFT;
  assign py_cell  = i_pixel_y >> Y_SHIFT;
  assign in_range = (i_pixel_x < PX_LIM) && (i_pixel_y < PY_LIM);
  assign rd_addr  = AW'(py_cell) * ROW_STEP + AW'(px_cell);
  assign rd_idx   = in_range ? rd_addr : '0;

  // Stage 1: cell index read
  always_ff @(posedge i_clk) begin
    rd_cell_q <= fb_mem[rd_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) inr_q <= 1'b0;
    else          inr_q <= in_range;
  end

  // Stage 2: palette lookup
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) color_q <= 12'h000;
    else          color_q <= inr_q ? pal_q[rd_cell_q] : 12'h000;
  end

  assign o_color = color_q;

endmodule

// File: tb/tb_gpu_cell_framebuffer.sv
// Scoreboard bench for gpu_cell_framebuffer: draw instructions, pixel reads, busy/error and reset behaviour.
module tb_gpu_cell_framebuffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic [11:0] color;
  logic [31:0] instr = '0;
  logic        ready = 1'b0;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  bit req = 1'b0, v1 = 1'b0, v2 = 1'b0;
  int bcnt = 0;

  gpu_cell_framebuffer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_x(px), .i_pixel_y(py), .o_color(color),
    .i_instruction(instr), .i_instruction_ready(ready), .o_busy(busy), .o_error(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w_pal(input logic [3:0] idx, input logic [11:0] c);
    return {2'b00, 2'b00, idx, 12'h000, c};
  endfunction
  function automatic logic [31:0] w_clr(input logic [3:0] idx);
    return {2'b01, 26'd0, idx};
  endfunction
  function automatic logic [31:0] w_rect(input logic [3:0] idx, input logic [6:0] x0,
                                         input logic [5:0] y0, input logic [6:0] x1,
                                         input logic [5:0] y1);
    return {2'b10, idx, x0, y0, x1, y1};
  endfunction

  always @(posedge clk) begin
    v1 <= req;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (busy) bcnt <= bcnt + 1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (exp_q.size() == 0) check("unexpected_pixel", {20'd0, color}, 32'hFFFF_FFFF);
      else check("pixel", {20'd0, color}, {20'd0, exp_q.pop_front()});
    end
  end

  task automatic issue(input logic [31:0] w);
    @(negedge clk);
    instr = w;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic read_px(input int x, input int y, input logic [11:0] e);
    @(negedge clk);
    px = 10'(x);
    py = 10'(y);
    req = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("idle_timeout", 32'(guard), 32'd0);
    @(negedge clk);
  endtask

  int b0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_color", {20'd0, color}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(w_pal(4'd1, 12'hF00));
    b0 = bcnt;
    issue(w_clr(4'd1));
    wait_idle();
    check("clear_busy_cycles", 32'(bcnt - b0), 32'd4560);
    check("clear_error", {31'd0, err}, 32'd0);
    read_px(0, 0, 12'hF00);
    read_px(303, 479, 12'hF00);

    issue(w_pal(4'd2, 12'h0F0));
    b0 = bcnt;
    issue(w_rect(4'd2, 7'd10, 6'd5, 7'd12, 6'd6));
    wait_idle();
    check("rect_busy_cycles", 32'(bcnt - b0), 32'd6);
    read_px(40, 40, 12'h0F0);
    read_px(51, 55, 12'h0F0);
    read_px(39, 40, 12'hF00);
    read_px(52, 40, 12'hF00);

    b0 = bcnt;
    issue(w_rect(4'd2, 7'd20, 6'd5, 7'd19, 6'd5));
    check("bad_rect_error", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    check("bad_rect_busy", 32'(bcnt - b0), 32'd0);
    read_px(80, 40, 12'hF00);

    read_px(320, 100, 12'h000);
    read_px(0, 480, 12'h000);

    // Second reset: clears error and palette, framebuffer contents survive.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_error", {31'd0, err}, 32'd0);
    issue(w_pal(4'd3, 12'h0FF));
    b0 = bcnt;
    issue(w_clr(4'd3));
    repeat (100) @(negedge clk);
    issue(w_rect(4'd1, 7'd0, 6'd0, 7'd0, 6'd0));
    check("drop_error", {31'd0, err}, 32'd1);
    wait_idle();
    check("drop_busy_cycles", 32'(bcnt - b0), 32'd4560);
    read_px(0, 0, 12'h0FF);
    read_px(303, 479, 12'h0FF);

    // Reset during a CLEAR: cells beyond the reset point keep the old index.
    px = 10'd303;
    py = 10'd479;
    repeat (3) @(negedge clk);
    check("pre_rst_color", {20'd0, color}, 32'h0FF);
    issue(w_clr(4'd1));
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_color", {20'd0, color}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(w_pal(4'd1, 12'h00F));
    read_px(0, 0, 12'h00F);
    read_px(96, 8, 12'h00F);
    read_px(303, 479, 12'h000);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
